insn_control_fsm: RTL

Multi-cycle control sequencer for the RV64 core that replaces the clock-gated instruction decoder. It takes the latched instruction and its one-hot opcode class and walks each instruction through fetch, decode, execute, memory and writeback states. It drives explicit write enables and request/ready handshakes to instruction memory, data memory and the FPU, where the old decoder used gated clocks. It sits between the opcode decoder and the datapath (ALU, register banks, PC register, memories) and also counts retired instructions.

---
 rtl/insn_ctrl_pkg.sv | 39 +++
 rtl/insn_control_fsm_branch_resolve.sv | 28 ++
 rtl/insn_control_fsm.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/insn_ctrl_pkg.sv
// Shared types and constants for the multi-cycle instruction control sequencer.
package insn_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC    = 4'd3,
        S_BR_TGT  = 4'd4,
        S_MEM     = 4'd5,
        S_FP_WAIT = 4'd6,
        S_WB      = 4'd7,
        S_TRAP    = 4'd8
    } state_t;

    localparam int C_LOAD   = 0;
    localparam int C_STORE  = 1;
    localparam int C_OP_IMM = 2;
    localparam int C_OP     = 3;
    localparam int C_BRANCH = 4;
    localparam int C_JAL    = 5;
    localparam int C_JALR   = 6;
    localparam int C_LUI    = 7;
    localparam int C_AUIPC  = 8;
    localparam int C_FP     = 9;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_SRX  = 3'b101;

    function automatic logic is_onehot(input logic [9:0] c);
        return (c != 10'd0) && ((c & (c - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/insn_control_fsm_branch_resolve.sv
// Combinational branch condition resolver: funct3 plus ALU compare flags to taken/illegal.
module branch_resolve
    import insn_ctrl_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_eq,
    input  logic       i_ls,
    input  logic       i_lu,
    output logic       o_taken,
    output logic       o_illegal
);

    // Decode branch type; funct3 010/011 have no branch encoding.
    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = i_eq;
            F3_BNE:  o_taken = !i_eq;
            F3_BLT:  o_taken = i_ls;
            F3_BGE:  o_taken = !i_ls;
            F3_BLTU: o_taken = i_lu;
            F3_BGEU: o_taken = !i_lu;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/insn_control_fsm.sv
// Multi-cycle instruction control sequencer: fetch/decode/execute/memory/writeback
// with explicit handshakes and write enables, plus a retired-instruction counter.
module insn_control_fsm
    import insn_ctrl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter bit FP_EN       = 1'b1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     insn,
    input  logic [9:0]      code,
    input  logic            EQ,
    input  logic            LS,
    input  logic            LU,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    input  logic            fpu_done,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            mem_we,
    output logic            addr_sel,
    output logic            pc_alu_sel,
    output logic            sub_sra,
    output logic            pc_next_sel,
    output logic            pc_we,
    output logic            rd_we,
    output logic            fpu_start,
    output logic            trap,
    output logic [XLEN-1:0] instret
);

    localparam int             CW       = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_funct3;
    logic          r_bit30;
    logic [9:0]    r_code;
    logic [CW-1:0] r_mem_cnt;
    logic          r_pc_we;
    logic          w_taken;
    logic          w_br_illegal;
    logic          w_illegal;
    logic          w_sub;
    logic          w_store_done;

    branch_resolve u_branch_resolve (
        .i_funct3  (r_funct3),
        .i_eq      (EQ),
        .i_ls      (LS),
        .i_lu      (LU),
        .o_taken   (w_taken),
        .o_illegal (w_br_illegal)
    );

    assign w_illegal = !is_onehot(r_code)
                     | (r_code[C_BRANCH] & w_br_illegal)
                     | (r_code[C_FP] & !FP_EN);
    assign w_sub = r_code[C_BRANCH]
                 | (r_code[C_OP] & r_bit30)
                 | (r_code[C_OP_IMM] & (r_funct3 == F3_SRX) & r_bit30);

    // A store retires in the cycle its ready arrives, so that pc_we is not registered.
    assign w_store_done = (r_state == S_MEM) & dmem_ready & r_code[C_STORE];
    assign pc_we        = r_pc_we | w_store_done;

    // Next-state selection.
    always_comb begin
        w_state_nxt = S_TRAP;
        case (r_state)
            S_IDLE:    w_state_nxt = S_FETCH;
            S_FETCH:   w_state_nxt = imem_ready ? S_DECODE : S_FETCH;
            S_DECODE:  w_state_nxt = w_illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                if (r_code[C_BRANCH]) begin
                    w_state_nxt = S_BR_TGT;
                end else if (r_code[C_LOAD] | r_code[C_STORE]) begin
                    w_state_nxt = S_MEM;
                end else if (r_code[C_FP]) begin
                    w_state_nxt = S_FP_WAIT;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_BR_TGT:  w_state_nxt = S_FETCH;
            S_MEM: begin
                if (dmem_ready) begin
                    w_state_nxt = r_code[C_STORE] ? S_FETCH : S_WB;
                end else if (r_mem_cnt == CNT_LAST) begin
                    w_state_nxt = S_TRAP;
                end else begin
                    w_state_nxt = S_MEM;
                end
            end
            S_FP_WAIT: w_state_nxt = fpu_done ? S_WB : S_FP_WAIT;
            S_WB:      w_state_nxt = S_FETCH;
            S_TRAP:    w_state_nxt = S_TRAP;
            default:   w_state_nxt = S_TRAP;
        endcase
    end

    // State, latched instruction fields and Moore outputs decoded from the entered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_funct3    <= 3'd0;
            r_bit30     <= 1'b0;
            r_code      <= 10'd0;
            r_mem_cnt   <= '0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            mem_we      <= 1'b0;
            addr_sel    <= 1'b0;
            pc_alu_sel  <= 1'b0;
            sub_sra     <= 1'b0;
            pc_next_sel <= 1'b0;
            r_pc_we     <= 1'b0;
            rd_we       <= 1'b0;
            fpu_start   <= 1'b0;
            trap        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_FETCH) && imem_ready) begin
                r_funct3 <= insn[14:12];
                r_bit30  <= insn[30];
                r_code   <= code;
            end else begin
                r_funct3 <= r_funct3;
                r_bit30  <= r_bit30;
                r_code   <= r_code;
            end
            if (r_state != S_MEM) begin
                r_mem_cnt <= '0;
            end else begin
                r_mem_cnt <= r_mem_cnt + CW'(1);
            end
            imem_req    <= (w_state_nxt == S_FETCH);
            dmem_req    <= (w_state_nxt == S_MEM);
            addr_sel    <= (w_state_nxt == S_MEM);
            mem_we      <= (w_state_nxt == S_MEM) & r_code[C_STORE];
            pc_alu_sel  <= ((w_state_nxt == S_EXEC) & (r_code[C_JAL] | r_code[C_AUIPC]))
                         | (w_state_nxt == S_BR_TGT);
            sub_sra     <= (w_state_nxt == S_EXEC) & w_sub;
            fpu_start   <= (w_state_nxt == S_EXEC) & r_code[C_FP];
            pc_next_sel <= ((w_state_nxt == S_BR_TGT) & w_taken)
                         | ((w_state_nxt == S_WB) & (r_code[C_JAL] | r_code[C_JALR]));
            r_pc_we     <= (w_state_nxt == S_BR_TGT) | (w_state_nxt == S_WB);
            rd_we       <= (w_state_nxt == S_WB);
            trap        <= (w_state_nxt == S_TRAP);
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (pc_we) begin
            instret <= instret + XLEN'(1);
        end else begin
            instret <= instret;
        end
    end

endmodule
